// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop synchroniser, 3-sample majority vote,
// frame FSM with parity/stop checking, and a first-word-fall-through receive FIFO.
module uart_rx_cfg #(
    parameter int unsigned CLK_PER_HALF_BIT = 5208,
    parameter int unsigned DATA_BITS        = 8,
    parameter int unsigned PARITY           = 0,
    parameter int unsigned STOP_BITS        = 1,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic                 busy
);

    localparam int unsigned BitT = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned CW   = $clog2(BitT) + 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned EW   = DATA_BITS + 2;

    localparam logic [CW-1:0] HalfLast = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BitLast  = CW'(BitT - 1);
    localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q, state_d;
    logic [1:0]             sync_q, hist_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   push_q, push_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic                   overrun_q, overrun_d;
    logic [EW-1:0]          mem_q [FIFO_DEPTH];

    logic          rxd_s, maj, full, empty, pop, wr_en;
    logic [EW-1:0] head;

    assign rxd_s = sync_q[1];
    // hist_q[0] is rxd_s one cycle ago, hist_q[1] two cycles ago
    assign maj   = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxd_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (maj) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StStop;
                    if (PARITY == 1)      perr_d = ~(^shift_q ^ maj);
                    else if (PARITY == 2) perr_d = ^shift_q ^ maj;
                    else                  perr_d = 1'b0;
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d     = '0;
                    ferr_d    = ferr_q | ~maj;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == StopLast) begin
                        push_d  = 1'b1;
                        state_d = maj ? StIdle : StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                cnt_d = '0;
                if (rxd_s) state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = rx_valid & rx_ready;
    // A full FIFO still accepts the frame when the head leaves on the same edge
    assign wr_en = push_q & (~full | pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(wr_en);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        overrun_d = (overrun_q & ~clear_overrun) | (push_q & full & ~pop);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            sync_q    <= 2'b11;
            hist_q    <= 2'b11;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            push_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rxd};
            hist_q    <= {hist_q[0], rxd_s};
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            push_q    <= push_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {ferr_q, perr_q, shift_q};
    end

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid = ~empty;
    // Gate the head so outputs read zero while empty, including during reset
    assign rx_data  = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_perr  = rx_valid & head[DATA_BITS];
    assign rx_ferr  = rx_valid & head[DATA_BITS+1];
    assign overrun  = overrun_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) with scoreboards
// fed by the stimulus tasks and drained by per-instance pop monitors.
module tb_uart_rx_cfg;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic       ready_a = 1'b0, ready_b = 1'b0, ready_c = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;
    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic       perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c;
    logic       valid_a, valid_b, valid_c, ovr_a, ovr_b, ovr_c;
    logic       busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    int pops_a = 0, pops_b = 0, pops_c = 0;
    logic [10:0] q_a [$];
    logic [10:0] q_b [$];
    logic [10:0] q_c [$];

    uart_rx_cfg #(.CLK_PER_HALF_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .rxd(rxd_a), .rx_data(data_a), .rx_perr(perr_a),
        .rx_ferr(ferr_a), .rx_valid(valid_a), .rx_ready(ready_a), .overrun(ovr_a),
        .clear_overrun(clr_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_PER_HALF_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
                  .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset_n(reset_n), .rxd(rxd_b), .rx_data(data_b), .rx_perr(perr_b),
        .rx_ferr(ferr_b), .rx_valid(valid_b), .rx_ready(ready_b), .overrun(ovr_b),
        .clear_overrun(clr_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_PER_HALF_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2),
                  .FIFO_DEPTH(4)) u_c (
        .clock(clock), .reset_n(reset_n), .rxd(rxd_c), .rx_data(data_c), .rx_perr(perr_c),
        .rx_ferr(ferr_c), .rx_valid(valid_c), .rx_ready(ready_c), .overrun(ovr_c),
        .clear_overrun(clr_c), .busy(busy_c));

    function automatic logic [10:0] ent(input logic f, input logic p, input logic [8:0] d);
        return {f, p, d};
    endfunction

    // Pop monitors: a pop happens on the next posedge whenever valid && ready here
    always @(negedge clock) begin
        if (reset_n && valid_a && ready_a) begin
            logic [10:0] exp_v, act_v;
            act_v = {ferr_a, perr_a, 1'b0, data_a};
            checks++;
            pops_a++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL sb_a unexpected frame actual=%h required=none", act_v);
            end else begin
                exp_v = q_a.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_a frame actual=%h required=%h", act_v, exp_v);
                end
            end
        end
        if (reset_n && valid_b && ready_b) begin
            logic [10:0] exp_v, act_v;
            act_v = {ferr_b, perr_b, 2'b00, data_b};
            checks++;
            pops_b++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL sb_b unexpected frame actual=%h required=none", act_v);
            end else begin
                exp_v = q_b.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_b frame actual=%h required=%h", act_v, exp_v);
                end
            end
        end
        if (reset_n && valid_c && ready_c) begin
            logic [10:0] exp_v, act_v;
            act_v = {ferr_c, perr_c, 1'b0, data_c};
            checks++;
            pops_c++;
            if (q_c.size() == 0) begin
                errors++;
                $display("FAIL sb_c unexpected frame actual=%h required=none", act_v);
            end else begin
                exp_v = q_c.pop_front();
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL sb_c frame actual=%h required=%h", act_v, exp_v);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input int idx, input logic v);
        case (idx)
            0:       rxd_a = v;
            1:       rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par_bit, input int nstop,
                              input logic last_stop);
        drive(idx, 1'b0);
        tick(8);
        for (int i = 0; i < nbits; i++) begin
            drive(idx, data[i]);
            tick(8);
        end
        if (has_par) begin
            drive(idx, par_bit);
            tick(8);
        end
        for (int s = 0; s < nstop; s++) begin
            drive(idx, (s == nstop - 1) ? last_stop : 1'b1);
            tick(8);
        end
        if (last_stop) drive(idx, 1'b1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(3);
        checks++;
        if ({valid_a, valid_b, valid_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_valid actual=%b required=000", {valid_a, valid_b, valid_c});
        end
        checks++;
        if ({busy_a, busy_b, busy_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy actual=%b required=000", {busy_a, busy_b, busy_c});
        end
        checks++;
        if ({ovr_a, ovr_b, ovr_c} !== 3'b000) begin
            errors++;
            $display("FAIL reset_overrun actual=%b required=000", {ovr_a, ovr_b, ovr_c});
        end
        checks++;
        if ({data_a, data_b, data_c, perr_a, ferr_a} !== 25'd0) begin
            errors++;
            $display("FAIL reset_data actual=%h/%h/%h pf=%b%b required=0", data_a, data_b,
                     data_c, perr_a, ferr_a);
        end
        reset_n = 1'b1;
        tick(4);
    endtask

    task automatic test_8n1;
        int p0;
        ready_a = 1'b1;
        p0 = pops_a;
        q_a.push_back(ent(1'b0, 1'b0, 9'h0A5));
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        tick(16);
        checks++;
        if (pops_a - p0 != 1) begin
            errors++;
            $display("FAIL 8n1_pulses actual=%0d required=1", pops_a - p0);
        end
        checks++;
        if (q_a.size() != 0 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_idle pending=%0d valid=%b busy=%b required=0/0/0", q_a.size(),
                     valid_a, busy_a);
        end
    endtask

    task automatic test_parity;
        ready_b = 1'b1;
        q_b.push_back(ent(1'b0, 1'b1, 9'h055));
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 1, 1'b1);
        tick(16);
        checks++;
        if (q_b.size() != 0) begin
            errors++;
            $display("FAIL parity_bad_missing pending actual=%0d required=0", q_b.size());
        end
        q_b.push_back(ent(1'b0, 1'b0, 9'h055));
        send_frame(1, 9'h055, 7, 1'b1, 1'b0, 1, 1'b1);
        tick(16);
        checks++;
        if (q_b.size() != 0 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL parity_good_missing pending=%0d valid=%b required=0/0", q_b.size(),
                     valid_b);
        end
    endtask

    task automatic test_glitch;
        drive(0, 1'b0);
        tick(2);
        drive(0, 1'b1);
        tick(2);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start busy actual=%b required=1", busy_a);
        end
        tick(12);
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject busy=%b valid=%b required=0/0", busy_a, valid_a);
        end
    endtask

    task automatic test_break;
        int p0;
        ready_c = 1'b1;
        p0 = pops_c;
        q_c.push_back(ent(1'b1, 1'b0, 9'h081));
        send_frame(2, 9'h081, 8, 1'b0, 1'b0, 2, 1'b0);
        tick(40);
        checks++;
        if (busy_c !== 1'b1 || pops_c - p0 != 1) begin
            errors++;
            $display("FAIL break_hold busy=%b frames=%0d required=1/1", busy_c, pops_c - p0);
        end
        drive(2, 1'b1);
        tick(16);
        checks++;
        if (busy_c !== 1'b0 || pops_c - p0 != 1) begin
            errors++;
            $display("FAIL break_release busy=%b frames=%0d required=0/1", busy_c, pops_c - p0);
        end
        q_c.push_back(ent(1'b0, 1'b0, 9'h03C));
        send_frame(2, 9'h03C, 8, 1'b0, 1'b0, 2, 1'b1);
        tick(16);
        checks++;
        if (q_c.size() != 0 || pops_c - p0 != 2) begin
            errors++;
            $display("FAIL break_next pending=%0d frames=%0d required=0/2", q_c.size(),
                     pops_c - p0);
        end
    endtask

    task automatic test_overrun;
        logic [8:0] v;
        ready_a = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            v = 9'(i);
            if (i <= 4) q_a.push_back(ent(1'b0, 1'b0, v));
            send_frame(0, v, 8, 1'b0, 1'b0, 1, 1'b1);
        end
        tick(16);
        checks++;
        if (ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set actual=%b required=1", ovr_a);
        end
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h01) begin
            errors++;
            $display("FAIL overrun_head valid=%b data=%h required=1/01", valid_a, data_a);
        end
        ready_a = 1'b1;
        tick(8);
        checks++;
        if (q_a.size() != 0 || valid_a !== 1'b0 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL overrun_drain pending=%0d valid=%b ovr=%b required=0/0/1",
                     q_a.size(), valid_a, ovr_a);
        end
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
        checks++;
        if (ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear actual=%b required=0", ovr_a);
        end
    endtask

    task automatic test_reset_midframe;
        int p0;
        ready_a = 1'b1;
        drive(0, 1'b0);
        tick(8);
        drive(0, 1'b1);
        tick(28);
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async busy=%b valid=%b required=0/0", busy_a, valid_a);
        end
        tick(4);
        reset_n = 1'b1;
        tick(16);
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle busy=%b valid=%b required=0/0", busy_a, valid_a);
        end
        p0 = pops_a;
        q_a.push_back(ent(1'b0, 1'b0, 9'h012));
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1);
        tick(16);
        checks++;
        if (q_a.size() != 0 || pops_a - p0 != 1) begin
            errors++;
            $display("FAIL midreset_frame pending=%0d frames=%0d required=0/1", q_a.size(),
                     pops_a - p0);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
